packet_classifier_mc: RTL and testbench

PACKET_CLASSIFIER_MC -- requirements
Module: packet_classifier_mc

---
 rtl/packet_classifier_mc.sv | 272 +++++++++++++++++++++++++++
 tb/tb_packet_classifier_mc.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_classifier_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// packet_classifier_mc : store-and-forward Avalon-ST classifier, NUM_PAT
// big-endian word patterns. Optional counters: PACKET_CLASSIFIER_STATS_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module packet_classifier_mc #(
  parameter int AMM_DWIDTH    = 32,
  parameter int AST_DWIDTH    = 64,
  parameter int PAT_WORDS     = 3,
  parameter int NUM_PAT       = 2,
  parameter int BUF_WORDS     = 256,
  parameter int CHANNEL_WIDTH = $clog2(NUM_PAT + 1),
  parameter int ADDR_WIDTH    = 8,
  parameter int EMPTY_WIDTH   = $clog2(AST_DWIDTH / 8)
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [ADDR_WIDTH-1:0]    amm_address_i,
  input  logic                     amm_write_i,
  input  logic [AMM_DWIDTH-1:0]    amm_writedata_i,
  input  logic                     amm_read_i,
  output logic [AMM_DWIDTH-1:0]    amm_readdata_o,
  output logic                     amm_readdatavalid_o,
  input  logic [AST_DWIDTH-1:0]    ast_sink_data_i,
  input  logic                     ast_sink_valid_i,
  input  logic                     ast_sink_sop_i,
  input  logic                     ast_sink_eop_i,
  input  logic [EMPTY_WIDTH-1:0]   ast_sink_empty_i,
  output logic                     ast_sink_ready_o,
  output logic [AST_DWIDTH-1:0]    ast_src_data_o,
  output logic                     ast_src_valid_o,
  output logic                     ast_src_sop_o,
  output logic                     ast_src_eop_o,
  output logic [EMPTY_WIDTH-1:0]   ast_src_empty_o,
  output logic [CHANNEL_WIDTH-1:0] ast_src_channel_o,
  input  logic                     ast_src_ready_i
);
  localparam int LANES      = AST_DWIDTH / AMM_DWIDTH;
  localparam int HIST       = PAT_WORDS - 1;
  localparam int COMB       = HIST + LANES;
  localparam int LANE_BYTES = AMM_DWIDTH / 8;
  localparam int BYTES      = AST_DWIDTH / 8;
  localparam int NWORDS     = NUM_PAT * PAT_WORDS;
  localparam int A_STAT     = 1 + NWORDS;
  localparam int BUF_AW     = $clog2(BUF_WORDS);
  localparam int PTR_W      = $clog2(BUF_WORDS + 1);

  typedef enum logic [2:0] {IDLE = 3'd0, RECV = 3'd1, WAIT = 3'd2, SEND = 3'd3, DROP = 3'd4} state_t;

  state_t                             state_q, state_d;
  logic [NUM_PAT:0]                   ctrl_q, ctrl_d;
  logic [NWORDS-1:0][AMM_DWIDTH-1:0]  pat_q, pat_d, pat_snap_q, pat_snap_d, pat_cmp;
  logic [NUM_PAT-1:0]                 en_snap_q, en_snap_d, hit_q, hit_d, beat_hit;
  logic [HIST-1:0][AMM_DWIDTH-1:0]    hist_w_q, hist_w_d;
  logic [HIST-1:0]                    hist_v_q, hist_v_d;
  logic [COMB-1:0][AMM_DWIDTH-1:0]    comb_w;
  logic [COMB-1:0]                    comb_v;
  logic                               win;
  logic [PTR_W-1:0]                   wr_cnt_q, wr_cnt_d;
  logic [BUF_AW-1:0]                  rd_ptr_q, rd_ptr_d, buf_waddr;
  logic [CHANNEL_WIDTH-1:0]           channel_q, channel_d;
  logic [AMM_DWIDTH-1:0]              readdata_q, readdata_d;
  logic                               rdvalid_q, rdvalid_d;
  logic                               start_pkt, store_beat, buf_we, drop_inc, match_inc, in_send, last_beat;
  logic [EMPTY_WIDTH+AST_DWIDTH-1:0]  buf_mem [BUF_WORDS];
  logic [EMPTY_WIDTH+AST_DWIDTH-1:0]  rd_word;

  // History lanes precede the new beat's lanes; a window must end in the new beat.
  always_comb begin
    for (int h = 0; h < HIST; h++) begin
      comb_w[h] = hist_w_q[h];
      comb_v[h] = hist_v_q[h] & ~ast_sink_sop_i;
    end
    for (int k = 0; k < LANES; k++) begin
      comb_w[HIST+k] = ast_sink_data_i[AST_DWIDTH-1-k*AMM_DWIDTH -: AMM_DWIDTH];
      comb_v[HIST+k] = !ast_sink_eop_i || ((k + 1) * LANE_BYTES <= BYTES - int'(ast_sink_empty_i));
    end
    pat_cmp  = ast_sink_sop_i ? pat_q : pat_snap_q;
    beat_hit = '0;
    win      = 1'b0;
    for (int p = 0; p < NUM_PAT; p++) begin
      for (int s = 0; s < LANES; s++) begin
        win = 1'b1;
        for (int w = 0; w < PAT_WORDS; w++) begin
          if (!comb_v[s+w] || comb_w[s+w] != pat_cmp[p*PAT_WORDS+w]) win = 1'b0;
        end
        if (win) beat_hit[p] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    pat_d      = pat_q;
    pat_snap_d = pat_snap_q;
    en_snap_d  = en_snap_q;
    hit_d      = hit_q;
    hist_w_d   = hist_w_q;
    hist_v_d   = hist_v_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    channel_d  = channel_q;
    start_pkt  = 1'b0;
    store_beat = 1'b0;
    drop_inc   = 1'b0;
    match_inc  = 1'b0;
    case (state_q)
      IDLE: if (ast_sink_valid_i && ast_sink_sop_i) begin
        if (ctrl_q[0]) begin
          start_pkt = 1'b1;
          state_d   = ast_sink_eop_i ? WAIT : RECV;
        end else if (!ast_sink_eop_i) begin
          state_d = DROP;
        end
      end
      RECV: if (ast_sink_valid_i) begin
        if (ast_sink_sop_i) begin
          start_pkt = 1'b1;
          drop_inc  = 1'b1;
          state_d   = ast_sink_eop_i ? WAIT : RECV;
        end else if (wr_cnt_q == PTR_W'(BUF_WORDS)) begin
          drop_inc = 1'b1;
          state_d  = ast_sink_eop_i ? IDLE : DROP;
        end else begin
          store_beat = 1'b1;
          if (ast_sink_eop_i) state_d = WAIT;
        end
      end
      WAIT: begin
        channel_d = '0;
        for (int p = NUM_PAT - 1; p >= 0; p--) begin
          if (hit_q[p] && en_snap_q[p]) channel_d = CHANNEL_WIDTH'(p + 1);
        end
        state_d = SEND;
      end
      SEND: if (ast_src_ready_i) begin
        if (last_beat) begin
          match_inc = 1'b1;
          state_d   = IDLE;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      DROP: if (ast_sink_valid_i && ast_sink_eop_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start_pkt) begin
      pat_snap_d = pat_q;
      en_snap_d  = ctrl_q[NUM_PAT:1];
      hit_d      = beat_hit;
      wr_cnt_d   = PTR_W'(1);
      rd_ptr_d   = '0;
    end else if (store_beat) begin
      hit_d    = hit_q | beat_hit;
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    if (start_pkt || store_beat) begin
      for (int h = 0; h < HIST; h++) begin
        hist_w_d[h] = comb_w[LANES+h];
        hist_v_d[h] = comb_v[LANES+h];
      end
    end

    if (amm_write_i) begin
      if (amm_address_i == ADDR_WIDTH'(0)) ctrl_d = amm_writedata_i[NUM_PAT:0];
      for (int i = 0; i < NWORDS; i++) begin
        if (amm_address_i == ADDR_WIDTH'(1 + i)) pat_d[i] = amm_writedata_i;
      end
    end
  end

  assign buf_we    = start_pkt || store_beat;
  assign buf_waddr = start_pkt ? '0 : wr_cnt_q[BUF_AW-1:0];
  assign rd_word   = buf_mem[rd_ptr_q];
  assign in_send   = (state_q == SEND);
  assign last_beat = (PTR_W'(rd_ptr_q) == wr_cnt_q - 1'b1);

  assign ast_sink_ready_o  = (state_q != WAIT) && (state_q != SEND);
  assign ast_src_valid_o   = in_send;
  assign ast_src_sop_o     = in_send && (rd_ptr_q == '0);
  assign ast_src_eop_o     = in_send && last_beat;
  assign ast_src_data_o    = in_send ? rd_word[AST_DWIDTH-1:0] : '0;
  assign ast_src_empty_o   = in_send ? rd_word[EMPTY_WIDTH+AST_DWIDTH-1:AST_DWIDTH] : '0;
  assign ast_src_channel_o = in_send ? channel_q : '0;
  assign amm_readdata_o      = readdata_q;
  assign amm_readdatavalid_o = rdvalid_q;

`ifdef PACKET_CLASSIFIER_STATS_EN
  logic [AMM_DWIDTH-1:0]              drop_cnt_q, drop_cnt_d;
  logic [NUM_PAT-1:0][AMM_DWIDTH-1:0] match_cnt_q, match_cnt_d;

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    match_cnt_d = match_cnt_q;
    if (drop_inc && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    for (int p = 0; p < NUM_PAT; p++) begin
      if (match_inc && channel_q == CHANNEL_WIDTH'(p + 1) && match_cnt_q[p] != '1)
        match_cnt_d[p] = match_cnt_q[p] + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      drop_cnt_q  <= '0;
      match_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = drop_inc ^ match_inc;
`endif

  always_comb begin
    rdvalid_d  = amm_read_i;
    readdata_d = '0;
    if (amm_read_i) begin
      if (amm_address_i == ADDR_WIDTH'(0)) readdata_d = AMM_DWIDTH'(ctrl_q);
      for (int i = 0; i < NWORDS; i++) begin
        if (amm_address_i == ADDR_WIDTH'(1 + i)) readdata_d = pat_q[i];
      end
`ifdef PACKET_CLASSIFIER_STATS_EN
      if (amm_address_i == ADDR_WIDTH'(A_STAT)) readdata_d = drop_cnt_q;
      for (int p = 0; p < NUM_PAT; p++) begin
        if (amm_address_i == ADDR_WIDTH'(A_STAT + 1 + p)) readdata_d = match_cnt_q[p];
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (buf_we) buf_mem[buf_waddr] <= {ast_sink_empty_i, ast_sink_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      pat_q      <= '0;
      pat_snap_q <= '0;
      en_snap_q  <= '0;
      hit_q      <= '0;
      hist_w_q   <= '0;
      hist_v_q   <= '0;
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      channel_q  <= '0;
      readdata_q <= '0;
      rdvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      pat_q      <= pat_d;
      pat_snap_q <= pat_snap_d;
      en_snap_q  <= en_snap_d;
      hit_q      <= hit_d;
      hist_w_q   <= hist_w_d;
      hist_v_q   <= hist_v_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      channel_q  <= channel_d;
      readdata_q <= readdata_d;
      rdvalid_q  <= rdvalid_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_packet_classifier_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_packet_classifier_mc : scoreboard bench for packet_classifier_mc.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_packet_classifier_mc;
`ifdef PACKET_CLASSIFIER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [31:0] PA = 32'hA1A2A3A4, PB = 32'hB1B2B3B4, PC = 32'hC1C2C3C4;
  localparam logic [31:0] PD = 32'hD1D2D3D4, PE = 32'hE1E2E3E4, PF = 32'hF1F2F3F4;
  localparam logic [31:0] F1 = 32'h11111111, F2 = 32'h22222222, F5 = 32'h55555555;
  localparam int A_STAT = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst = 1'b1;
  logic [7:0]  amm_address = '0;
  logic        amm_write = 1'b0, amm_read = 1'b0;
  logic [31:0] amm_writedata = '0, amm_readdata;
  logic        amm_readdatavalid;
  logic [63:0] sink_data = '0, src_data;
  logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0, sink_ready;
  logic [2:0]  sink_empty = '0, src_empty;
  logic        src_valid, src_sop, src_eop, src_ready = 1'b1;
  logic [1:0]  src_channel;

  packet_classifier_mc dut (
    .clk_i(clk), .srst_i(srst),
    .amm_address_i(amm_address), .amm_write_i(amm_write), .amm_writedata_i(amm_writedata),
    .amm_read_i(amm_read), .amm_readdata_o(amm_readdata), .amm_readdatavalid_o(amm_readdatavalid),
    .ast_sink_data_i(sink_data), .ast_sink_valid_i(sink_valid), .ast_sink_sop_i(sink_sop),
    .ast_sink_eop_i(sink_eop), .ast_sink_empty_i(sink_empty), .ast_sink_ready_o(sink_ready),
    .ast_src_data_o(src_data), .ast_src_valid_o(src_valid), .ast_src_sop_o(src_sop),
    .ast_src_eop_o(src_eop), .ast_src_empty_o(src_empty), .ast_src_channel_o(src_channel),
    .ast_src_ready_i(src_ready)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic [1:0]  chan;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_exp, mon_got;
  logic [63:0] pkt[$];
  int          n_checks = 0, n_fail = 0;
  int          exp_match[2] = '{0, 0};
  logic [31:0] rd;

  // Scoreboard: every accepted output beat is popped and compared.
  always @(negedge clk) begin
    if (src_valid && src_ready) begin
      n_checks++;
      mon_got = {src_data, src_sop, src_eop, src_empty, src_channel};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_src_beat: got %h, required no output", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL src_beat: got %h, required %h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input int a, input logic [31:0] d);
    amm_address = 8'(a); amm_writedata = d; amm_write = 1'b1;
    tick();
    amm_write = 1'b0;
  endtask

  task automatic read_reg(input int a, output logic [31:0] d);
    amm_address = 8'(a); amm_read = 1'b1;
    tick();
    amm_read = 1'b0;
    d = amm_readdatavalid ? amm_readdata : 'x;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic s, input logic e, input logic [2:0] emp);
    sink_data = d; sink_sop = s; sink_eop = e; sink_empty = emp; sink_valid = 1'b1;
    for (int i = 0; i < 400 && !sink_ready; i++) tick();
    if (!sink_ready) begin
      n_checks++; n_fail++;
      $display("FAIL sink_ready_timeout: got ready=0, required 1");
    end
    tick();
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_empty = '0;
  endtask

  task automatic send_pkt(input logic [2:0] emp);
    for (int i = 0; i < pkt.size(); i++)
      drive_beat(pkt[i], i == 0, i == pkt.size() - 1, (i == pkt.size() - 1) ? emp : 3'd0);
  endtask

  task automatic expect_pkt(input int chan, input logic [2:0] emp);
    beat_t b;
    for (int i = 0; i < pkt.size(); i++) begin
      b.data  = pkt[i];
      b.sop   = (i == 0);
      b.eop   = (i == pkt.size() - 1);
      b.empty = b.eop ? emp : 3'd0;
      b.chan  = 2'(chan);
      exp_q.push_back(b);
    end
    if (chan != 0) exp_match[chan-1]++;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && (exp_q.size() != 0 || src_valid); i++) tick();
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
    end
    tick();
  endtask

  task automatic check_reg(input string name, input int a, input logic [31:0] req);
    read_reg(a, rd);
    n_checks++;
    if (rd !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, rd, req);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({src_valid, src_sop, src_eop, src_empty, src_channel, src_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_src_outputs: got v=%b s=%b e=%b emp=%0d ch=%0d d=%h, required all 0",
               src_valid, src_sop, src_eop, src_empty, src_channel, src_data);
    end
    n_checks++;
    if (sink_ready !== 1'b1) begin n_fail++; $display("FAIL reset_sink_ready: got %b, required 1", sink_ready); end
    n_checks++;
    if (amm_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_rdvalid: got %b, required 0", amm_readdatavalid); end
    srst = 1'b0;
    tick();
    check_reg("reset_ctrl", 0, 32'h0);
    check_reg("reset_pattern", 2, 32'h0);
    check_reg("reset_drop_cnt", A_STAT, 32'h0);
  endtask

  task automatic test_basic();
    write_reg(1, PA); write_reg(2, PB); write_reg(3, PC);
    write_reg(0, 32'h3);
    check_reg("pattern_readback", 2, PB);
    pkt = '{{F1, PA}, {PB, PC}, {F2, F2}};
    expect_pkt(1, 3'd0);
    send_pkt(3'd0);
    n_checks++;
    if (src_valid !== 1'b0) begin n_fail++; $display("FAIL latency_wait: got valid=%b, required 0", src_valid); end
    tick();
    n_checks++;
    if (src_valid !== 1'b1) begin n_fail++; $display("FAIL latency_first: got valid=%b, required 1", src_valid); end
    wait_drain();
  endtask

  task automatic test_split();
    pkt = '{{F1, F1}, {F2, PA}, {PB, PC}};
    expect_pkt(1, 3'd0);
    send_pkt(3'd0);
    wait_drain();
    expect_pkt(0, 3'd4);
    send_pkt(3'd4);
    wait_drain();
    pkt = '{{PA, PB}};
    expect_pkt(0, 3'd0);
    send_pkt(3'd0);
    wait_drain();
  endtask

  task automatic test_priority();
    write_reg(4, PD); write_reg(5, PE); write_reg(6, PF);
    write_reg(0, 32'h7);
    pkt = '{{PA, PB}, {PC, PD}, {PE, PF}, {F1, F2}};
    expect_pkt(1, 3'd0);
    send_pkt(3'd0);
    wait_drain();
    write_reg(0, 32'h5);
    expect_pkt(2, 3'd0);
    send_pkt(3'd0);
    wait_drain();
    write_reg(0, 32'h3);
    pkt = '{{F1, PD}, {PE, PF}};
    expect_pkt(0, 3'd0);
    send_pkt(3'd0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [70:0] snap, prev_snap;
    logic        prev_valid, prev_ready;
    prev_snap = '0; prev_valid = 1'b0; prev_ready = 1'b1;
    write_reg(0, 32'h7);
    pkt = '{{F1, F5}, {F2, PA}, {PB, PC}, {F5, F1}};
    expect_pkt(1, 3'd0);
    src_ready = 1'b1;
    send_pkt(3'd0);
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0 && !src_valid) break;
      snap = {src_data, src_sop, src_eop, src_empty, src_channel};
      if (prev_valid && !prev_ready) begin
        n_checks++;
        if (!src_valid || snap !== prev_snap) begin
          n_fail++;
          $display("FAIL stall_hold: got %h, required %h", snap, prev_snap);
        end
      end
      if (src_valid) begin
        n_checks++;
        if (sink_ready !== 1'b0) begin n_fail++; $display("FAIL send_sink_ready: got %b, required 0", sink_ready); end
      end
      prev_valid = src_valid; prev_snap = snap;
      src_ready = ~src_ready; prev_ready = src_ready;
      tick();
    end
    src_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_midpacket_write();
    write_reg(0, 32'h3);
    pkt = '{{F1, F1}, {PA, PB}, {PC, F2}, {F2, F2}};
    expect_pkt(1, 3'd0);
    drive_beat(pkt[0], 1'b1, 1'b0, 3'd0);
    write_reg(1, 32'h12345678);
    drive_beat(pkt[1], 1'b0, 1'b0, 3'd0);
    drive_beat(pkt[2], 1'b0, 1'b0, 3'd0);
    drive_beat(pkt[3], 1'b0, 1'b1, 3'd0);
    wait_drain();
    expect_pkt(0, 3'd0);
    send_pkt(3'd0);
    wait_drain();
    write_reg(1, PA);
  endtask

  task automatic test_drop();
    write_reg(0, 32'h0);
    pkt = '{{PA, PB}, {PC, F1}, {F1, F1}, {F2, F2}};
    send_pkt(3'd0);
    repeat (6) tick();
    check_reg("drop_cnt_disabled", A_STAT, 32'h0);
    write_reg(0, 32'h3);
    pkt.delete();
    for (int i = 0; i < 257; i++) pkt.push_back(64'hFEED_0000_0000_0000 | 64'(i));
    send_pkt(3'd0);
    repeat (6) tick();
    check_reg("drop_cnt_overflow", A_STAT, STATS ? 32'd1 : 32'd0);
    write_reg(0, 32'h7);
    drive_beat({F5, F5}, 1'b1, 1'b0, 3'd0);
    drive_beat({F1, F5}, 1'b0, 1'b0, 3'd0);
    pkt = '{{PD, PE}, {PF, F1}};
    expect_pkt(2, 3'd0);
    send_pkt(3'd0);
    wait_drain();
    check_reg("drop_cnt_restart", A_STAT, STATS ? 32'd2 : 32'd0);
  endtask

  task automatic test_counters();
    check_reg("match_cnt0", A_STAT + 1, STATS ? 32'(exp_match[0]) : 32'd0);
    check_reg("match_cnt1", A_STAT + 2, STATS ? 32'(exp_match[1]) : 32'd0);
    check_reg("unmapped_read", 12, 32'h0);
  endtask

  task automatic test_reset_in_send();
    write_reg(0, 32'h3);
    src_ready = 1'b0;
    pkt = '{{F1, F1}, {F2, F2}, {F5, F5}, {F1, F2}, {F2, F5}, {F5, F1}};
    send_pkt(3'd0);
    for (int i = 0; i < 10 && !src_valid; i++) tick();
    n_checks++;
    if (src_valid !== 1'b1) begin n_fail++; $display("FAIL send_reached: got valid=%b, required 1", src_valid); end
    srst = 1'b1;
    tick();
    n_checks++;
    if ({src_valid, src_sop, src_eop, src_channel, src_data} !== '0 || sink_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_send: got valid=%b ready=%b ch=%0d d=%h, required valid=0 ready=1 ch=0 d=0",
               src_valid, sink_ready, src_channel, src_data);
    end
    srst = 1'b0;
    src_ready = 1'b1;
    tick();
    check_reg("ctrl_after_reset", 0, 32'h0);
    check_reg("pattern_after_reset", 1, 32'h0);
    check_reg("match_cnt_after_reset", A_STAT + 1, 32'h0);
    // Patterns are all-zero after reset, so three zero lanes hit pattern 0.
    write_reg(0, 32'h3);
    pkt = '{{32'h0, 32'h0}, {32'h0, F5}};
    expect_pkt(1, 3'd0);
    send_pkt(3'd0);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_priority();
    test_backpressure();
    test_midpacket_write();
    test_drop();
    test_counters();
    test_reset_in_send();
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
